// File: rtl/dp_ram_pkg.sv
// dp_ram_pkg
// Shared definitions for the parametrised dual-port RAM slice:
//   - clr_state_e : clear-sequencer states (ST_INIT, ST_RUN)
//   - nb_lanes()  : number of byte lanes in a word
//   - lanes_divide(): elaboration-time check that the word splits into whole lanes
package dp_ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } clr_state_e;

  function automatic int nb_lanes(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  function automatic bit lanes_divide(input int data_w, input int byte_w);
    return (byte_w > 0) && ((data_w % byte_w) == 0);
  endfunction

endpackage

// File: rtl/dp_ram_clr.sv
// dp_ram_clr
// Post-reset clear sequencer. Walks every address once, issuing an all-zero
// write strobe per cycle, then releases the ports.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (restarts the clear at 0)
//   clr_we     out  write strobe for the clear word this cycle
//   clr_addr   out  address being cleared
//   init_busy  out  1 while the clear is running (ST_INIT)
module dp_ram_clr
  import dp_ram_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              init_busy
);

  clr_state_e        state;
  clr_state_e        state_next;
  logic [ADDR_W-1:0] clr_addr_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      clr_addr <= '0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
    end
  end

  // The strobe is suppressed while rst is high so a reset cycle never
  // counts as a clear step; the clear always takes DEPTH rst-low cycles.
  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    clr_we        = 1'b0;
    init_busy     = 1'b0;
    case (state)
      ST_INIT: begin
        init_busy = 1'b1;
        if (!rst) begin
          clr_we        = 1'b1;
          clr_addr_next = clr_addr + 1'b1;
          if (clr_addr == {ADDR_W{1'b1}}) begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        init_busy = 1'b0;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

endmodule

// File: rtl/dp_ram_param.sv
// dp_ram_param
// Parametrised true dual-port synchronous RAM with per-byte write enables,
// read-first same-address behaviour, port-A-wins write-write resolution,
// registered collision flags and a post-reset clear sequence.
// Ports:
//   clk, rst                         clock and synchronous active-high reset
//   en_x, we_x, be_x, addr_x, data_x port x request (x = a, b)
//   q_x, vld_x                       port x read data and read-valid pulse
//   init_busy                        clear running, port requests ignored
//   coll_ww                          both ports wrote the same address, overlapping lanes
//   coll_rw                          one port read an address the other wrote
// Optional macro DP_RAM_PARAM_OUT_REG_EN adds a second output register stage
// (read latency 2) on q, vld and both collision flags.
module dp_ram_param
  import dp_ram_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int BYTE_W = 8,
  parameter  int ADDR_W = 6,
  localparam int NB     = nb_lanes(DATA_W, BYTE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [NB-1:0]     be_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] q_a,
  output logic              vld_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [NB-1:0]     be_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] q_b,
  output logic              vld_b,
  output logic              init_busy,
  output logic              coll_ww,
  output logic              coll_rw
);

  localparam int DEPTH = 2 ** ADDR_W;

  if (!lanes_divide(DATA_W, BYTE_W)) begin : g_bad_lane_width
    $error("dp_ram_param: DATA_W must be a multiple of BYTE_W");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              run;
  logic              rd_a, wr_a, rd_b, wr_b;
  logic              same_addr;
  logic              ww_hit, rw_hit;

  logic [DATA_W-1:0] q1_a, q1_b;
  logic              vld1_a, vld1_b;
  logic              ww1, rw1;

  dp_ram_clr #(
    .ADDR_W(ADDR_W)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .init_busy(init_busy)
  );

  // Requests are only honoured once the clear has finished and reset is
  // low. A write with no lanes enabled is treated as no request at all, so
  // it can neither modify memory nor raise a collision flag.
  always_comb begin
    run       = !init_busy && !rst;
    rd_a      = run && en_a && !we_a;
    rd_b      = run && en_b && !we_b;
    wr_a      = run && en_a && we_a && (|be_a);
    wr_b      = run && en_b && we_b && (|be_b);
    same_addr = (addr_a == addr_b);
    ww_hit    = wr_a && wr_b && same_addr && (|(be_a & be_b));
    rw_hit    = same_addr && ((rd_a && wr_b) || (rd_b && wr_a));
  end

  // Array write path. The clear sequencer owns the array while it runs.
  // Port B lanes are written first and port A lanes afterwards in the same
  // block, so on a shared address and lane the later port A assignment wins
  // while lanes enabled by only one port keep that port's data.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (wr_b) begin
        for (int i = 0; i < NB; i++) begin
          if (be_b[i]) begin
            mem[addr_b][i*BYTE_W +: BYTE_W] <= data_b[i*BYTE_W +: BYTE_W];
          end
        end
      end
      if (wr_a) begin
        for (int i = 0; i < NB; i++) begin
          if (be_a[i]) begin
            mem[addr_a][i*BYTE_W +: BYTE_W] <= data_a[i*BYTE_W +: BYTE_W];
          end
        end
      end
    end
  end

  // First output stage. The array is sampled with non-blocking semantics,
  // so a read racing a write to the same address returns the old word.
  // Writes leave q untouched (no-change mode).
  always_ff @(posedge clk) begin
    if (rst) begin
      q1_a   <= '0;
      q1_b   <= '0;
      vld1_a <= 1'b0;
      vld1_b <= 1'b0;
      ww1    <= 1'b0;
      rw1    <= 1'b0;
    end else begin
      vld1_a <= rd_a;
      vld1_b <= rd_b;
      ww1    <= ww_hit;
      rw1    <= rw_hit;
      if (rd_a) begin
        q1_a <= mem[addr_a];
      end
      if (rd_b) begin
        q1_b <= mem[addr_b];
      end
    end
  end

`ifdef DP_RAM_PARAM_OUT_REG_EN
  logic [DATA_W-1:0] q2_a, q2_b;
  logic              vld2_a, vld2_b;
  logic              ww2, rw2;

  // Second output stage: everything shifts by one cycle together so the
  // collision flags stay aligned with vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      q2_a   <= '0;
      q2_b   <= '0;
      vld2_a <= 1'b0;
      vld2_b <= 1'b0;
      ww2    <= 1'b0;
      rw2    <= 1'b0;
    end else begin
      q2_a   <= q1_a;
      q2_b   <= q1_b;
      vld2_a <= vld1_a;
      vld2_b <= vld1_b;
      ww2    <= ww1;
      rw2    <= rw1;
    end
  end

  assign q_a     = q2_a;
  assign q_b     = q2_b;
  assign vld_a   = vld2_a;
  assign vld_b   = vld2_b;
  assign coll_ww = ww2;
  assign coll_rw = rw2;
`else
  assign q_a     = q1_a;
  assign q_b     = q1_b;
  assign vld_a   = vld1_a;
  assign vld_b   = vld1_b;
  assign coll_ww = ww1;
  assign coll_rw = rw1;
`endif

endmodule

// File: tb/tb_dp_ram_param.sv
// tb_dp_ram_param
// Self-checking bench for dp_ram_param (DATA_W=32, BYTE_W=8, ADDR_W=6).
// Honours DP_RAM_PARAM_OUT_REG_EN to pick the expected read latency.
module tb_dp_ram_param;

`ifdef DP_RAM_PARAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, we_a, en_b, we_b;
  logic [3:0]  be_a, be_b;
  logic [5:0]  addr_a, addr_b;
  logic [31:0] data_a, data_b;
  logic [31:0] q_a, q_b;
  logic        vld_a, vld_b, init_busy, coll_ww, coll_rw;

  int vectors    = 0;
  int miscompares = 0;

  dp_ram_param #(
    .DATA_W(32),
    .BYTE_W(8),
    .ADDR_W(6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en_a     (en_a),
    .we_a     (we_a),
    .be_a     (be_a),
    .addr_a   (addr_a),
    .data_a   (data_a),
    .q_a      (q_a),
    .vld_a    (vld_a),
    .en_b     (en_b),
    .we_b     (we_b),
    .be_b     (be_b),
    .addr_b   (addr_b),
    .data_b   (data_b),
    .q_b      (q_b),
    .vld_b    (vld_b),
    .init_busy(init_busy),
    .coll_ww  (coll_ww),
    .coll_rw  (coll_rw)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    en_a = 1'b0; we_a = 1'b0; be_a = 4'h0; addr_a = '0; data_a = '0;
    en_b = 1'b0; we_b = 1'b0; be_b = 4'h0; addr_b = '0; data_b = '0;
  endtask

  task automatic set_a(input logic we, input logic [3:0] be, input logic [5:0] addr, input logic [31:0] data);
    en_a = 1'b1; we_a = we; be_a = be; addr_a = addr; data_a = data;
  endtask

  task automatic set_b(input logic we, input logic [3:0] be, input logic [5:0] addr, input logic [31:0] data);
    en_b = 1'b1; we_b = we; be_b = be; addr_b = addr; data_b = data;
  endtask

  // Issue the current request for one edge, then idle until its result is visible.
  task automatic issue_and_wait();
    tick();
    idle_ports();
    repeat (LAT - 1) tick();
  endtask

  task automatic test_reset();
    int busy_cycles;
    rst = 1'b1;
    idle_ports();
    tick();
    tick();
    vectors++;
    if (q_a !== 32'h0 || q_b !== 32'h0 || vld_a !== 1'b0 || vld_b !== 1'b0 ||
        coll_ww !== 1'b0 || coll_rw !== 1'b0 || init_busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_values: got q_a=%h q_b=%h vld=%b%b ww=%b rw=%b busy=%b expected zeros and busy=1",
               q_a, q_b, vld_a, vld_b, coll_ww, coll_rw, init_busy);
    end
    rst = 1'b0;
    busy_cycles = 0;
    while (init_busy === 1'b1 && busy_cycles < 300) begin
      tick();
      busy_cycles++;
    end
    vectors++;
    if (busy_cycles != DEPTH) begin
      miscompares++;
      $display("[TB] FAIL clear_duration: got %0d busy cycles expected %0d", busy_cycles, DEPTH);
    end
    set_a(1'b0, 4'h0, 6'h3F, 32'h0);
    set_b(1'b0, 4'h0, 6'h00, 32'h0);
    issue_and_wait();
    vectors++;
    if (vld_a !== 1'b1 || q_a !== 32'h0 || vld_b !== 1'b1 || q_b !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL read_after_clear: got vld_a=%b q_a=%h vld_b=%b q_b=%h expected 1/0 1/0",
               vld_a, q_a, vld_b, q_b);
    end
    tick();
    vectors++;
    if (vld_a !== 1'b0 || vld_b !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL vld_pulse: got vld_a=%b vld_b=%b expected 0 0", vld_a, vld_b);
    end
  endtask

  task automatic test_byte_merge();
    repeat (2) tick();
    set_a(1'b1, 4'b1111, 6'h05, 32'hDEADBEEF);
    tick();
    idle_ports();
    set_b(1'b1, 4'b0001, 6'h05, 32'h000000AA);
    tick();
    idle_ports();
    repeat (LAT) tick();
    vectors++;
    if (vld_a !== 1'b0 || vld_b !== 1'b0 || q_a !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL write_no_change: got vld_a=%b vld_b=%b q_a=%h expected 0 0 00000000",
               vld_a, vld_b, q_a);
    end
    set_a(1'b0, 4'h0, 6'h05, 32'h0);
    set_b(1'b0, 4'h0, 6'h05, 32'h0);
    issue_and_wait();
    vectors++;
    if (vld_a !== 1'b1 || q_a !== 32'hDEADBEAA || vld_b !== 1'b1 || q_b !== 32'hDEADBEAA) begin
      miscompares++;
      $display("[TB] FAIL byte_merge: got vld_a=%b q_a=%h vld_b=%b q_b=%h expected DEADBEAA on both",
               vld_a, q_a, vld_b, q_b);
    end
    tick();
    vectors++;
    if (q_a !== 32'hDEADBEAA || vld_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL q_hold: got q_a=%h vld_a=%b expected DEADBEAA 0", q_a, vld_a);
    end
  endtask

  task automatic test_ww_collision();
    set_a(1'b1, 4'b0011, 6'h10, 32'h11111111);
    set_b(1'b1, 4'b0110, 6'h10, 32'h22222222);
    issue_and_wait();
    vectors++;
    if (coll_ww !== 1'b1 || coll_rw !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL coll_ww_flag: got ww=%b rw=%b expected 1 0", coll_ww, coll_rw);
    end
    tick();
    vectors++;
    if (coll_ww !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL coll_ww_pulse: got %b expected 0", coll_ww);
    end
    set_a(1'b0, 4'h0, 6'h10, 32'h0);
    issue_and_wait();
    vectors++;
    if (vld_a !== 1'b1 || q_a !== 32'h00221111) begin
      miscompares++;
      $display("[TB] FAIL ww_merge: got vld_a=%b q_a=%h expected 1 00221111", vld_a, q_a);
    end
  endtask

  task automatic test_rw_collision();
    tick();
    set_a(1'b0, 4'h0, 6'h20, 32'h0);
    set_b(1'b1, 4'b1111, 6'h20, 32'h5A5A5A5A);
    issue_and_wait();
    vectors++;
    if (vld_a !== 1'b1 || q_a !== 32'h0 || coll_rw !== 1'b1 || coll_ww !== 1'b0 || vld_b !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL read_first: got vld_a=%b q_a=%h rw=%b ww=%b vld_b=%b expected 1 00000000 1 0 0",
               vld_a, q_a, coll_rw, coll_ww, vld_b);
    end
    set_b(1'b0, 4'h0, 6'h20, 32'h0);
    issue_and_wait();
    vectors++;
    if (vld_b !== 1'b1 || q_b !== 32'h5A5A5A5A || coll_rw !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rw_followup: got vld_b=%b q_b=%h rw=%b expected 1 5A5A5A5A 0",
               vld_b, q_b, coll_rw);
    end
  endtask

  task automatic test_reset_mid_clear();
    int busy_cycles;
    set_a(1'b1, 4'b1111, 6'h07, 32'h12345678);
    tick();
    idle_ports();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    // Writes hammered during the clear must all be dropped.
    set_a(1'b1, 4'b1111, 6'h07, 32'hFFFFFFFF);
    set_b(1'b1, 4'b1111, 6'h08, 32'hCAFEF00D);
    repeat (30) tick();
    vectors++;
    if (init_busy !== 1'b1 || vld_a !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL busy_mid_clear: got busy=%b vld_a=%b expected 1 0", init_busy, vld_a);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busy_cycles = 0;
    while (init_busy === 1'b1 && busy_cycles < 300) begin
      tick();
      busy_cycles++;
    end
    idle_ports();
    vectors++;
    if (busy_cycles != DEPTH) begin
      miscompares++;
      $display("[TB] FAIL restart_duration: got %0d busy cycles expected %0d", busy_cycles, DEPTH);
    end
    set_a(1'b0, 4'h0, 6'h07, 32'h0);
    set_b(1'b0, 4'h0, 6'h08, 32'h0);
    issue_and_wait();
    vectors++;
    if (vld_a !== 1'b1 || q_a !== 32'h0 || vld_b !== 1'b1 || q_b !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL write_during_init: got vld_a=%b q_a=%h vld_b=%b q_b=%h expected 1/0 1/0",
               vld_a, q_a, vld_b, q_b);
    end
  endtask

  typedef struct {
    logic        va, vb, ww, rw;
    logic [31:0] qa, qb;
  } exp_t;

  // Randomised traffic on a narrow address window so collisions are common.
  // The model is a plain word array; both q registers start at 0 because the
  // preceding reset cleared them and only zero words have been read since.
  task automatic test_random();
    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_qa, exp_qb;
    exp_t        expq [$];
    exp_t        e, got;
    logic        rda, rdb, wra, wrb;
    int          n_ops;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    exp_qa = 32'h0;
    exp_qb = 32'h0;
    n_ops  = 400;
    for (int k = 0; k < n_ops + LAT; k++) begin
      if (k < n_ops) begin
        en_a = 1'($urandom_range(0, 3) != 0); we_a = 1'($urandom);
        be_a = 4'($urandom); addr_a = 6'($urandom_range(0, 3)); data_a = $urandom;
        en_b = 1'($urandom_range(0, 3) != 0); we_b = 1'($urandom);
        be_b = 4'($urandom); addr_b = 6'($urandom_range(0, 3)); data_b = $urandom;
      end else begin
        idle_ports();
      end
      rda = en_a && !we_a;
      rdb = en_b && !we_b;
      wra = en_a && we_a && (be_a != 4'h0);
      wrb = en_b && we_b && (be_b != 4'h0);
      if (rda) exp_qa = model_mem[addr_a];
      if (rdb) exp_qb = model_mem[addr_b];
      e.va = rda;
      e.vb = rdb;
      e.qa = exp_qa;
      e.qb = exp_qb;
      e.ww = wra && wrb && (addr_a == addr_b) && ((be_a & be_b) != 4'h0);
      e.rw = (addr_a == addr_b) && ((rda && wrb) || (rdb && wra));
      for (int l = 0; l < 4; l++) begin
        if (wra && be_a[l])
          model_mem[addr_a][l*8 +: 8] = data_a[l*8 +: 8];
        else if (wrb && be_b[l] && !(wra && addr_a == addr_b && be_a[l]))
          model_mem[addr_b][l*8 +: 8] = data_b[l*8 +: 8];
        if (wrb && be_b[l] && addr_a != addr_b)
          model_mem[addr_b][l*8 +: 8] = data_b[l*8 +: 8];
      end
      expq.push_back(e);
      tick();
      if (expq.size() == LAT) begin
        e = expq.pop_front();
        got.va = vld_a; got.vb = vld_b; got.qa = q_a; got.qb = q_b;
        got.ww = coll_ww; got.rw = coll_rw;
        vectors++;
        if (got.va !== e.va || got.vb !== e.vb || got.qa !== e.qa || got.qb !== e.qb ||
            got.ww !== e.ww || got.rw !== e.rw) begin
          miscompares++;
          $display("[TB] FAIL random_op%0d: got va=%b qa=%h vb=%b qb=%h ww=%b rw=%b expected va=%b qa=%h vb=%b qb=%h ww=%b rw=%b",
                   k - LAT + 1, got.va, got.qa, got.vb, got.qb, got.ww, got.rw,
                   e.va, e.qa, e.vb, e.qb, e.ww, e.rw);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_ports();
    test_reset();
    test_byte_merge();
    test_ww_collision();
    test_rw_collision();
    test_reset_mid_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
